// File: rtl/conv_encoder_framer.sv
// conv_encoder_framer
//   Frames a stream of information bits and convolutionally encodes it
//   (rate 1/2, constraint length 4, 8 states). Each frame is FRAME_LEN data
//   symbols followed by 3 zero-tail symbols that flush the encoder to 000.
//   The symbol stream never stalls: a DATA cycle without bit_valid encodes a
//   zero bit and raises the sticky underflow flag.
//
//   Optional build macro ERR_INJECT_EN: when defined, c0 of every
//   err_period-th valid symbol of a frame is inverted (1-based, restarting
//   each frame, err_period = 0 disables). When undefined, err_period is
//   accepted but ignored and no injection logic exists.
//
// Parameters
//   FRAME_LEN   information bits per frame, 1..65535
// Ports
//   clk         rising-edge clock
//   rst         asynchronous, active-low reset
//   start       one-cycle pulse starting a frame (honoured only in IDLE)
//   bit_in      information bit
//   bit_valid   bit_in is valid
//   bit_ready   high in DATA; bit taken when bit_valid & bit_ready
//   err_period  symbol-error interval (ERR_INJECT_EN builds only)
//   sym_out     encoded symbol {c1,c0}, 00 when sym_valid is low
//   sym_valid   sym_out carries a frame symbol
//   dec_enable  decoder enable, identical to sym_valid
//   underflow   sticky: a zero bit was substituted for missing input
//   frame_done  one-cycle pulse after the final tail symbol
module conv_encoder_framer #(
    parameter int unsigned FRAME_LEN = 1024
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       bit_in,
    input  logic       bit_valid,
    output logic       bit_ready,
    input  logic [7:0] err_period,
    output logic [1:0] sym_out,
    output logic       sym_valid,
    output logic       dec_enable,
    output logic       underflow,
    output logic       frame_done
);

    typedef enum logic [1:0] {
        IDLE,
        DATA,
        TAIL,
        DONE
    } state_t;

    localparam logic [15:0] LAST_BIT  = 16'(FRAME_LEN - 1);
    localparam logic [15:0] LAST_TAIL = 16'd2;

    state_t      state;
    logic [2:0]  sr;        // encoder shift register, sr[0] newest
    logic [15:0] bit_cnt;   // data bits in DATA, tail bits in TAIL

    logic encoding;
    logic enc_bit;
    logic c1;
    logic c0;
    logic inject;
    logic start_ok;

    // The cycle frame_done is high is still IDLE, yet a start there must be
    // dropped, so acceptance is gated by frame_done as well as the state.
    assign start_ok = start && (state == IDLE) && !frame_done;

    always_comb begin
        encoding = (state == DATA) || (state == TAIL);
        enc_bit  = (state == DATA) ? (bit_valid & bit_in) : 1'b0;
        c1       = enc_bit ^ sr[0] ^ sr[1] ^ sr[2];
        c0       = enc_bit ^ sr[1] ^ sr[2];
    end

`ifdef ERR_INJECT_EN
    logic [7:0] err_cnt;    // valid symbols since last injection

    assign inject = encoding && (err_period != 8'd0) &&
                    ((err_cnt + 8'd1) == err_period);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            err_cnt <= '0;
        end else if (start_ok) begin
            err_cnt <= '0;
        end else if (encoding) begin
            err_cnt <= inject ? 8'd0 : err_cnt + 8'd1;
        end
    end
`else
    logic unused_err_period;

    assign inject            = 1'b0;
    assign unused_err_period = ^err_period;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            sr         <= '0;
            bit_cnt    <= '0;
            bit_ready  <= 1'b0;
            sym_out    <= '0;
            sym_valid  <= 1'b0;
            dec_enable <= 1'b0;
            underflow  <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            sym_valid  <= encoding;
            dec_enable <= encoding;
            sym_out    <= encoding ? {c1, c0 ^ inject} : 2'b00;
            if (encoding) begin
                sr <= {sr[1:0], enc_bit};
            end

            case (state)
                IDLE: begin
                    if (start_ok) begin
                        state     <= DATA;
                        sr        <= '0;
                        bit_cnt   <= '0;
                        underflow <= 1'b0;
                        bit_ready <= 1'b1;
                    end
                end
                DATA: begin
                    if (!bit_valid) begin
                        underflow <= 1'b1;
                    end
                    if (bit_cnt == LAST_BIT) begin
                        state     <= TAIL;
                        bit_cnt   <= '0;
                        bit_ready <= 1'b0;
                    end else begin
                        bit_cnt <= bit_cnt + 16'd1;
                    end
                end
                TAIL: begin
                    if (bit_cnt == LAST_TAIL) begin
                        state   <= DONE;
                        bit_cnt <= '0;
                    end else begin
                        bit_cnt <= bit_cnt + 16'd1;
                    end
                end
                DONE: begin
                    // last tail symbol is on sym_out during this cycle
                    state      <= IDLE;
                    frame_done <= 1'b1;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_conv_encoder_framer.sv
module tb_conv_encoder_framer;

`ifdef ERR_INJECT_EN
    localparam bit INJ = 1'b1;
`else
    localparam bit INJ = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       start = 1'b0;
    logic       bit_in = 1'b0;
    logic       bit_valid = 1'b0;
    logic [7:0] err_period = 8'd3;

    logic       s4_rdy, s4_sv, s4_de, s4_uf, s4_done;
    logic [1:0] s4_sym;
    logic       sk_rdy, sk_sv, sk_de, sk_uf, sk_done;
    logic [1:0] sk_sym;
    logic       s1_rdy, s1_sv, s1_de, s1_uf, s1_done;
    logic [1:0] s1_sym;

    conv_encoder_framer #(.FRAME_LEN(4)) u4 (
        .clk(clk), .rst(rst), .start(start), .bit_in(bit_in),
        .bit_valid(bit_valid), .bit_ready(s4_rdy), .err_period(err_period),
        .sym_out(s4_sym), .sym_valid(s4_sv), .dec_enable(s4_de),
        .underflow(s4_uf), .frame_done(s4_done));

    conv_encoder_framer #(.FRAME_LEN(1024)) u1k (
        .clk(clk), .rst(rst), .start(start), .bit_in(bit_in),
        .bit_valid(bit_valid), .bit_ready(sk_rdy), .err_period(err_period),
        .sym_out(sk_sym), .sym_valid(sk_sv), .dec_enable(sk_de),
        .underflow(sk_uf), .frame_done(sk_done));

    conv_encoder_framer #(.FRAME_LEN(1)) u1 (
        .clk(clk), .rst(rst), .start(start), .bit_in(bit_in),
        .bit_valid(bit_valid), .bit_ready(s1_rdy), .err_period(err_period),
        .sym_out(s1_sym), .sym_valid(s1_sv), .dec_enable(s1_de),
        .underflow(s1_uf), .frame_done(s1_done));

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // one row = inputs for a cycle, outputs expected right after its edge
    typedef struct {
        logic       st;
        logic       b;
        logic       v;
        logic [1:0] sym;
        logic [1:0] sym_inj;
        logic       sv;
        logic       rdy;
        logic       done;
        logic       uf;
    } vec_t;

    localparam int NV = 24;
    vec_t tbl [0:NV-1];

    logic       bits [0:1023];
    logic [1:0] exp_k [0:1026];

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [2:0]  m;
        logic        b, c1, c0;
        int          nsym, first, last, done_k, de_bad;
        logic [1:0]  got1 [0:7];
        logic [1:0]  exp1 [0:3];
        int          n1;
        logic        d1;

        // frame A: bits 1,0,1,1; start during DONE and frame_done cycles
        tbl[0]  = '{1'b1, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0};
        tbl[1]  = '{1'b0, 1'b1, 1'b1, 2'b11, 2'b11, 1'b1, 1'b1, 1'b0, 1'b0};
        tbl[2]  = '{1'b0, 1'b0, 1'b1, 2'b10, 2'b10, 1'b1, 1'b1, 1'b0, 1'b0};
        tbl[3]  = '{1'b0, 1'b1, 1'b1, 2'b00, 2'b01, 1'b1, 1'b1, 1'b0, 1'b0};
        tbl[4]  = '{1'b0, 1'b1, 1'b1, 2'b10, 2'b10, 1'b1, 1'b0, 1'b0, 1'b0};
        tbl[5]  = '{1'b0, 1'b0, 1'b0, 2'b01, 2'b01, 1'b1, 1'b0, 1'b0, 1'b0};
        tbl[6]  = '{1'b0, 1'b0, 1'b0, 2'b00, 2'b01, 1'b1, 1'b0, 1'b0, 1'b0};
        tbl[7]  = '{1'b0, 1'b0, 1'b0, 2'b11, 2'b11, 1'b1, 1'b0, 1'b0, 1'b0};
        tbl[8]  = '{1'b1, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0, 1'b1, 1'b0};
        tbl[9]  = '{1'b1, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[10] = '{1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0};
        // frame B: bits 1,(missing with bit_in=1),0,1; start held through TAIL/DONE
        tbl[11] = '{1'b1, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0};
        tbl[12] = '{1'b0, 1'b1, 1'b1, 2'b11, 2'b11, 1'b1, 1'b1, 1'b0, 1'b0};
        tbl[13] = '{1'b0, 1'b1, 1'b0, 2'b10, 2'b10, 1'b1, 1'b1, 1'b0, 1'b1};
        tbl[14] = '{1'b0, 1'b0, 1'b1, 2'b11, 2'b10, 1'b1, 1'b1, 1'b0, 1'b1};
        tbl[15] = '{1'b0, 1'b1, 1'b1, 2'b00, 2'b00, 1'b1, 1'b0, 1'b0, 1'b1};
        tbl[16] = '{1'b1, 1'b0, 1'b0, 2'b10, 2'b10, 1'b1, 1'b0, 1'b0, 1'b1};
        tbl[17] = '{1'b1, 1'b0, 1'b0, 2'b11, 2'b10, 1'b1, 1'b0, 1'b0, 1'b1};
        tbl[18] = '{1'b1, 1'b0, 1'b0, 2'b11, 2'b11, 1'b1, 1'b0, 1'b0, 1'b1};
        tbl[19] = '{1'b1, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0, 1'b1, 1'b1};
        tbl[20] = '{1'b1, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1};
        // frame C: new start clears underflow, then left mid-DATA for reset
        tbl[21] = '{1'b1, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0};
        tbl[22] = '{1'b0, 1'b0, 1'b1, 2'b00, 2'b00, 1'b1, 1'b1, 1'b0, 1'b0};
        tbl[23] = '{1'b0, 1'b1, 1'b0, 2'b00, 2'b00, 1'b1, 1'b1, 1'b0, 1'b1};

        // ---- reset state
        tick();
        tick();
        check("reset_u4", {s4_sym, s4_sv, s4_de, s4_rdy, s4_done, s4_uf}, 32'd0);
        check("reset_u1k", {sk_sym, sk_sv, sk_de, sk_rdy, sk_done, sk_uf}, 32'd0);
        @(negedge clk);
        rst = 1'b1;
        tick();

        // ---- 1024-bit random frame
        for (int i = 0; i < 1024; i++) bits[i] = 1'($urandom_range(0, 1));
        m = 3'b000;
        for (int i = 0; i < 1027; i++) begin
            b  = (i < 1024) ? bits[i] : 1'b0;
            c1 = b ^ m[0] ^ m[1] ^ m[2];
            c0 = b ^ m[1] ^ m[2];
            if (INJ && ((i + 1) % 3 == 0)) c0 = ~c0;
            exp_k[i] = {c1, c0};
            m = {m[1:0], b};
        end
        start = 1'b1;
        bit_valid = 1'b1;
        tick();
        start = 1'b0;
        nsym = 0; first = -1; last = -1; done_k = -1; de_bad = 0;
        for (int k = 0; k < 1100 && done_k < 0; k++) begin
            bit_in = (k < 1024) ? bits[k] : 1'b0;
            tick();
            if (sk_de !== sk_sv) de_bad++;
            if (sk_sv === 1'b1) begin
                if (nsym < 1027) check($sformatf("sym1k_%0d", nsym), 32'(sk_sym), 32'(exp_k[nsym]));
                if (first < 0) first = k;
                last = k;
                nsym++;
            end
            if (sk_done === 1'b1) done_k = k;
        end
        bit_valid = 1'b0;
        bit_in = 1'b0;
        check("count1k", nsym, 1027);
        check("first1k", first, 0);
        check("contig1k", last - first + 1, nsym);
        check("done1k_pos", done_k, last + 1);
        check("de_eq_sv1k", de_bad, 0);
        check("final_sr1k", 32'(u1k.sr), 32'd0);
        check("uf1k", 32'(sk_uf), 32'd0);

        // ---- FRAME_LEN = 1: one data plus three tail symbols
        repeat (3) tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        bit_in = 1'b1;
        bit_valid = 1'b1;
        n1 = 0; d1 = 1'b0;
        for (int k = 0; k < 10 && !d1; k++) begin
            tick();
            bit_valid = 1'b0;
            bit_in = 1'b0;
            if (s1_sv === 1'b1 && n1 < 8) begin
                got1[n1] = s1_sym;
                n1++;
            end
            if (s1_done === 1'b1) d1 = 1'b1;
        end
        exp1[0] = 2'b11;
        exp1[1] = 2'b10;
        exp1[2] = INJ ? 2'b10 : 2'b11;
        exp1[3] = 2'b11;
        check("count_len1", n1, 4);
        for (int i = 0; i < 4; i++)
            if (i < n1) check($sformatf("sym_len1_%0d", i), 32'(got1[i]), 32'(exp1[i]));
        check("done_len1", 32'(d1), 32'd1);
        repeat (10) tick();

        // ---- table-driven FRAME_LEN = 4 frames
        for (int i = 0; i < NV; i++) begin
            start     = tbl[i].st;
            bit_in    = tbl[i].b;
            bit_valid = tbl[i].v;
            tick();
            check($sformatf("row%0d", i),
                  {s4_sym, s4_sv, s4_de, s4_rdy, s4_done, s4_uf},
                  {(INJ ? tbl[i].sym_inj : tbl[i].sym), tbl[i].sv, tbl[i].sv,
                   tbl[i].rdy, tbl[i].done, tbl[i].uf});
        end
        start = 1'b0;

        // ---- asynchronous reset mid-DATA (u1k is also mid-frame)
        #2;
        rst = 1'b0;
        #1;
        check("async_rst_u4", {s4_sym, s4_sv, s4_de, s4_rdy, s4_done, s4_uf}, 32'd0);
        check("async_rst_u1k", {sk_sym, sk_sv, sk_de, sk_rdy, sk_done, sk_uf}, 32'd0);
        tick();
        @(negedge clk);
        rst = 1'b1;
        bit_valid = 1'b1;
        bit_in = 1'b1;
        for (int k = 0; k < 6; k++) begin
            tick();
            check($sformatf("post_rst_%0d", k), {s4_sym, s4_sv, s4_rdy, s4_done}, 32'd0);
        end
        start = 1'b1;
        bit_valid = 1'b0;
        tick();
        start = 1'b0;
        check("restart_rdy", 32'(s4_rdy), 32'd1);
        bit_in = 1'b1;
        bit_valid = 1'b1;
        tick();
        check("restart_sym", {s4_sym, s4_sv}, {2'b11, 1'b1});
        bit_valid = 1'b0;
        repeat (12) tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
